// File: rtl/alu_mul_sequencer.sv
// Multi-cycle unsigned 32x32 shift-and-add multiplier (low 32 product bits)
// that borrows the shared single-cycle ALU for every add and shift step.
module alu_mul_sequencer #(
   parameter int unsigned ITER_MAX   = 32,
   parameter bit          EARLY_EXIT = 1'b1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        START,
   input  logic [31:0] MCAND,
   input  logic [31:0] MPLIER,
   input  logic [31:0] ALU_RESULT,
   output logic [31:0] ALU_A,
   output logic [31:0] ALU_B,
   output logic        ALU_SRC,
   output logic [2:0]  ALU_CONTROL,
   output logic        BUSY,
   output logic        DONE,
   output logic [31:0] PRODUCT
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 6;
   localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(ITER_MAX);
   localparam logic [2:0] ALU_OP_ADD = 3'b000;
   localparam logic [2:0] ALU_OP_SHL = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ADD   = 2'd1,
      S_SHIFT = 2'd2,
      S_FIN   = 2'd3
   } state_t;

   state_t              state, state_nxt;
   logic [DATA_W-1:0]   acc, acc_nxt;
   logic [DATA_W-1:0]   mc, mc_nxt;
   logic [DATA_W-1:0]   mp, mp_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [DATA_W-1:0]   product_q, product_nxt;

   // Operand B always comes from the register-file path.
   assign ALU_SRC = 1'b0;
   assign PRODUCT = product_q;

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state     <= S_IDLE;
         acc       <= '0;
         mc        <= '0;
         mp        <= '0;
         cnt       <= '0;
         product_q <= '0;
      end else begin
         state     <= state_nxt;
         acc       <= acc_nxt;
         mc        <= mc_nxt;
         mp        <= mp_nxt;
         cnt       <= cnt_nxt;
         product_q <= product_nxt;
      end
   end

   // Next-state, datapath update and ALU drive decoded from the current state.
   always_comb begin
      state_nxt   = state;
      acc_nxt     = acc;
      mc_nxt      = mc;
      mp_nxt      = mp;
      cnt_nxt     = cnt;
      product_nxt = product_q;
      ALU_A       = '0;
      ALU_B       = '0;
      ALU_CONTROL = ALU_OP_ADD;
      BUSY        = 1'b0;
      DONE        = 1'b0;

      unique case (state)
         S_IDLE: begin
            if (START) begin
               acc_nxt = '0;
               mc_nxt  = MCAND;
               mp_nxt  = MPLIER;
               cnt_nxt = '0;
               if (EARLY_EXIT && (MPLIER == '0)) begin
                  state_nxt = S_FIN;
               end else if (MPLIER[0]) begin
                  state_nxt = S_ADD;
               end else begin
                  state_nxt = S_SHIFT;
               end
            end
         end

         S_ADD: begin
            ALU_A       = acc;
            ALU_B       = mc;
            ALU_CONTROL = ALU_OP_ADD;
            BUSY        = 1'b1;
            acc_nxt     = ALU_RESULT;
            state_nxt   = S_SHIFT;
         end

         S_SHIFT: begin
            ALU_A       = mc;
            ALU_B       = DATA_W'(1);
            ALU_CONTROL = ALU_OP_SHL;
            BUSY        = 1'b1;
            mc_nxt      = ALU_RESULT;
            mp_nxt      = mp >> 1;
            cnt_nxt     = cnt + CNT_W'(1);
            // Stop on the iteration limit or when no multiplier bits remain.
            if ((cnt_nxt == ITER_LAST) || (EARLY_EXIT && (mp_nxt == '0))) begin
               state_nxt = S_FIN;
            end else if (mp[1]) begin
               state_nxt = S_ADD;
            end else begin
               state_nxt = S_SHIFT;
            end
         end

         S_FIN: begin
            DONE        = 1'b1;
            product_nxt = acc;
            state_nxt   = S_IDLE;
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench: two sequencers (early exit on / off) share stimulus;
// each has its own combinational ALU and its own schedule-based reference model.
module tb_alu_mul_sequencer;

   localparam int K_IDLE  = 0;
   localparam int K_ADD   = 1;
   localparam int K_SHIFT = 2;
   localparam int K_FIN   = 3;
   localparam int ITER    = 32;

   typedef struct {
      int          kind;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] prod;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] mcand, mplier;

   logic [31:0] res_e, a_e, b_e, prod_e_dut;
   logic [31:0] res_n, a_n, b_n, prod_n_dut;
   logic [2:0]  ctl_e, ctl_n;
   logic        src_e, src_n, busy_e, busy_n, done_e, done_n;

   int errors = 0;
   int checks = 0;

   ent_t        qe[$];
   ent_t        qn[$];
   logic [31:0] mprod_e, mprod_n;
   bit          live = 1'b0;

   always #5 clk = ~clk;

   // Shared-ALU stand-ins: add or shift-left, combinational.
   assign res_e = (ctl_e == 3'b000) ? a_e + b_e : (ctl_e == 3'b111) ? a_e << b_e[4:0] : 32'd0;
   assign res_n = (ctl_n == 3'b000) ? a_n + b_n : (ctl_n == 3'b111) ? a_n << b_n[4:0] : 32'd0;

   alu_mul_sequencer #(.ITER_MAX(ITER), .EARLY_EXIT(1'b1)) u_dut_e (
      .CLK(clk), .RST(rst), .START(start), .MCAND(mcand), .MPLIER(mplier),
      .ALU_RESULT(res_e), .ALU_A(a_e), .ALU_B(b_e), .ALU_SRC(src_e),
      .ALU_CONTROL(ctl_e), .BUSY(busy_e), .DONE(done_e), .PRODUCT(prod_e_dut)
   );

   alu_mul_sequencer #(.ITER_MAX(ITER), .EARLY_EXIT(1'b0)) u_dut_n (
      .CLK(clk), .RST(rst), .START(start), .MCAND(mcand), .MPLIER(mplier),
      .ALU_RESULT(res_n), .ALU_A(a_n), .ALU_B(b_n), .ALU_SRC(src_n),
      .ALU_CONTROL(ctl_n), .BUSY(busy_n), .DONE(done_n), .PRODUCT(prod_n_dut)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Expected per-cycle schedule of one multiply, derived from multiplier bits.
   task automatic push_sched(input int which, input logic [31:0] a, input logic [31:0] b);
      int   n;
      ent_t e;
      if (which == 0) begin
         n = 0;
         for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
      end else begin
         n = ITER;
      end
      for (int k = 0; k < n; k++) begin
         logic [31:0] mask;
         mask = 32'((64'd1 << k) - 64'd1);
         if (b[k]) begin
            e.kind = K_ADD; e.a = a * (b & mask); e.b = a << k; e.prod = 32'd0;
            if (which == 0) qe.push_back(e); else qn.push_back(e);
         end
         e.kind = K_SHIFT; e.a = a << k; e.b = 32'd1; e.prod = 32'd0;
         if (which == 0) qe.push_back(e); else qn.push_back(e);
      end
      e.kind = K_FIN; e.a = 32'd0; e.b = 32'd0; e.prod = a * b;
      if (which == 0) qe.push_back(e); else qn.push_back(e);
   endtask

   // Reference model: advance each schedule one step per clock.
   always @(posedge clk) begin
      if (!rst) begin
         qe.delete(); qn.delete();
         mprod_e = 32'd0; mprod_n = 32'd0;
         live = 1'b1;
      end else begin
         if (qe.size() == 0) begin
            if (start) push_sched(0, mcand, mplier);
         end else begin
            if (qe[0].kind == K_FIN) mprod_e = qe[0].prod;
            void'(qe.pop_front());
         end
         if (qn.size() == 0) begin
            if (start) push_sched(1, mcand, mplier);
         end else begin
            if (qn[0].kind == K_FIN) mprod_n = qn[0].prod;
            void'(qn.pop_front());
         end
      end
   end

   task automatic cmp_inst(input int which);
      ent_t        e;
      logic [31:0] aa, bb, pp, ep;
      logic [2:0]  ctl;
      logic        busy, done, src;
      string       tag;
      e.kind = K_IDLE; e.a = 32'd0; e.b = 32'd0; e.prod = 32'd0;
      if (which == 0) begin
         if (qe.size() != 0) e = qe[0];
         aa = a_e; bb = b_e; pp = prod_e_dut; ctl = ctl_e; busy = busy_e; done = done_e; src = src_e;
         ep = mprod_e; tag = "ee";
      end else begin
         if (qn.size() != 0) e = qn[0];
         aa = a_n; bb = b_n; pp = prod_n_dut; ctl = ctl_n; busy = busy_n; done = done_n; src = src_n;
         ep = mprod_n; tag = "ne";
      end
      chk({tag, ".busy"},    32'(busy), 32'((e.kind == K_ADD) || (e.kind == K_SHIFT)));
      chk({tag, ".done"},    32'(done), 32'(e.kind == K_FIN));
      chk({tag, ".ctl"},     32'(ctl),  (e.kind == K_SHIFT) ? 32'd7 : 32'd0);
      chk({tag, ".alu_a"},   aa, e.a);
      chk({tag, ".alu_b"},   bb, e.b);
      chk({tag, ".alu_src"}, 32'(src), 32'd0);
      chk({tag, ".product"}, pp, ep);
   endtask

   // Cycle-by-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (live) begin
         cmp_inst(0);
         cmp_inst(1);
      end
   end

   // Launch one multiply, optionally poke START mid-run, wait until both idle.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int poke_at,
                         output int be, output int bn, output int de, output int dn);
      int cyc;
      be = 0; bn = 0; de = 0; dn = 0;
      cyc = 0;
      while ((qe.size() != 0 || qn.size() != 0) && cyc < 200) begin
         @(posedge clk); #1; cyc++;
      end
      if (cyc >= 200) chk("idle_timeout_pre", 32'd1, 32'd0);
      start = 1'b1; mcand = a; mplier = b;
      @(posedge clk); #1;
      start = 1'b0; mcand = $urandom; mplier = $urandom;
      cyc = 0;
      while ((qe.size() != 0 || qn.size() != 0) && cyc < 200) begin
         if (busy_e) be++;
         if (busy_n) bn++;
         if (done_e) de++;
         if (done_n) dn++;
         start = (cyc == poke_at);
         if (start) begin mcand = $urandom; mplier = $urandom; end
         @(posedge clk); #1; cyc++;
      end
      start = 1'b0;
      if (cyc >= 200) chk("done_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      int be, bn, de, dn;
      rst = 1'b0; start = 1'b0; mcand = 32'd0; mplier = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.product", prod_e_dut, 32'd0);
      chk("rst.busy",    32'(busy_e), 32'd0);
      chk("rst.done",    32'(done_e), 32'd0);
      chk("rst.ctl",     32'(ctl_e),  32'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      run_op(32'd3, 32'd5, -1, be, bn, de, dn);
      chk("3x5.busy_cycles", 32'(be), 32'd5);
      chk("3x5.done_pulses", 32'(de), 32'd1);
      chk("3x5.product",     prod_e_dut, 32'd15);
      chk("3x5.ne_busy",     32'(bn), 32'd34);

      run_op(32'd1234, 32'd0, -1, be, bn, de, dn);
      chk("x0.busy_cycles", 32'(be), 32'd0);
      chk("x0.done_pulses", 32'(de), 32'd1);
      chk("x0.product",     prod_e_dut, 32'd0);

      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, be, bn, de, dn);
      chk("ff.busy_cycles", 32'(be), 32'd64);
      chk("ff.product",     prod_e_dut, 32'd1);
      chk("ff.ne_product",  prod_n_dut, 32'd1);

      run_op(32'd7, 32'd1, -1, be, bn, de, dn);
      chk("7x1.ne_busy",    32'(bn), 32'd33);
      chk("7x1.ne_product", prod_n_dut, 32'd7);
      chk("7x1.ee_busy",    32'(be), 32'd2);

      // START pulsed while busy must be ignored.
      run_op(32'd3, 32'd5, 2, be, bn, de, dn);
      chk("poke.product",    prod_e_dut, 32'd15);
      chk("poke.ne_product", prod_n_dut, 32'd15);

      // Reset in the middle of an operation, then a clean restart.
      start = 1'b1; mcand = 32'd3; mplier = 32'd5;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("midrst.busy",    32'(busy_e), 32'd0);
      chk("midrst.done",    32'(done_e), 32'd0);
      chk("midrst.product", prod_e_dut, 32'd0);
      chk("midrst.alu_a",   a_e, 32'd0);
      rst = 1'b1;
      run_op(32'd6, 32'd7, -1, be, bn, de, dn);
      chk("6x7.product",    prod_e_dut, 32'd42);
      chk("6x7.ne_product", prod_n_dut, 32'd42);

      // Randomized operands with assorted multiplier shapes.
      for (int t = 0; t < 150; t++) begin
         logic [31:0] a, b;
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = $urandom;
            1: b = 32'($urandom_range(0, 255));
            2: b = 32'd0;
            default: b = 32'd1 << $urandom_range(0, 31);
         endcase
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         run_op(a, b, ($urandom_range(0, 3) == 0) ? 1 : -1, be, bn, de, dn);
      end

      @(posedge clk); #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
